// File: rtl/debug_stream_serializer.sv
// Buffered MSB-first debug word serializer: FIFO of words, generated bit clock,
// frame strobe, configurable inter-frame gap, valid/ready and sticky overflow.
module debug_stream_serializer #(
  parameter int DATA_WIDTH = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4,
  parameter int GAP_BITS   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          data_valid,
  input  logic [DATA_WIDTH-1:0]         data,
  output logic                          data_ready,
  input  logic                          overflow_clr,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          sclk,
  output logic                          sout,
  output logic                          sframe
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int GAP_W = $clog2(GAP_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  logic [DIV_W-1:0]      div_cnt;
  logic                  sclk_q;
  logic                  div_last;
  logic                  fall_tick;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  load;
  logic                  shift;
  logic [DATA_WIDTH-1:0] head;
  logic                  ovf_q;

  state_t                state, state_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [GAP_W-1:0]      gap_cnt, gap_nxt;
  logic                  sout_q, sout_nxt;
  logic                  sframe_q, sframe_nxt;
  logic [DATA_WIDTH-1:0] shreg;

  // Bit clock: sclk toggles at the end of every CLK_DIV-cycle half-period;
  // serial outputs move only on its falling edge so they are stable at the rise.
  assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall_tick = div_last && sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk_q  <= 1'b0;
    end else if (div_last) begin
      div_cnt <= '0;
      sclk_q  <= ~sclk_q;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Word FIFO; ready comes from the registered level, so a pop in the same
  // cycle never opens a slot for a push offered while full.
  assign full       = (level == LVL_W'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign push       = data_valid && !full;
  assign head       = mem[rd_ptr];
  assign data_ready = !full;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, load})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a new rejected offer beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf_q <= 1'b0;
    else if (data_valid && full) ovf_q <= 1'b1;
    else if (overflow_clr)       ovf_q <= 1'b0;
  end
  assign overflow = ovf_q;

  // Frame sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      sout_q   <= 1'b0;
      sframe_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_nxt;
      gap_cnt  <= gap_nxt;
      sout_q   <= sout_nxt;
      sframe_q <= sframe_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bit_nxt    = bit_cnt;
    gap_nxt    = gap_cnt;
    sout_nxt   = sout_q;
    sframe_nxt = sframe_q;
    load       = 1'b0;
    shift      = 1'b0;
    if (fall_tick) begin
      case (state)
        S_IDLE: begin
          sout_nxt   = 1'b0;
          sframe_nxt = 1'b0;
          if (!empty) load = 1'b1;
        end
        S_SHIFT: begin
          if (bit_cnt == BIT_W'(DATA_WIDTH)) begin
            sout_nxt   = 1'b0;
            sframe_nxt = 1'b0;
            gap_nxt    = '0;
            state_nxt  = S_GAP;
          end else begin
            shift    = 1'b1;
            sout_nxt = shreg[DATA_WIDTH-2];
            bit_nxt  = bit_cnt + BIT_W'(1);
          end
        end
        S_GAP: begin
          sout_nxt   = 1'b0;
          sframe_nxt = 1'b0;
          if (gap_cnt == GAP_W'(GAP_BITS - 1)) begin
            if (!empty) load = 1'b1;
            else        state_nxt = S_IDLE;
          end else begin
            gap_nxt = gap_cnt + GAP_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    // A load drives the MSB immediately and counts it as the first bit sent.
    if (load) begin
      state_nxt  = S_SHIFT;
      sout_nxt   = head[DATA_WIDTH-1];
      sframe_nxt = 1'b1;
      bit_nxt    = BIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load)       shreg <= head;
    else if (shift) shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
  end

  assign sclk   = sclk_q;
  assign sout   = sout_q;
  assign sframe = sframe_q;
  assign busy   = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_debug_stream_serializer.sv
// Directed bench for debug_stream_serializer: three parameterisations share clk/rst_n;
// a monitor rebuilds frames from sclk/sout/sframe and a scoreboard checks them.
module tb_debug_stream_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // A: defaults, B: CLK_DIV=8, C: 8-bit words, CLK_DIV=1, GAP_BITS=1
  logic        dv_a, rdy_a, oclr_a, ovf_a, busy_a, sclk_a, sout_a, sfr_a;
  logic [39:0] d_a;
  logic [2:0]  lvl_a;
  logic        dv_b, rdy_b, oclr_b, ovf_b, busy_b, sclk_b, sout_b, sfr_b;
  logic [39:0] d_b;
  logic [2:0]  lvl_b;
  logic        dv_c, rdy_c, oclr_c, ovf_c, busy_c, sclk_c, sout_c, sfr_c;
  logic [7:0]  d_c;
  logic [2:0]  lvl_c;

  debug_stream_serializer u_a (
    .clk(clk), .rst_n(rst_n), .data_valid(dv_a), .data(d_a), .data_ready(rdy_a),
    .overflow_clr(oclr_a), .overflow(ovf_a), .fifo_level(lvl_a), .busy(busy_a),
    .sclk(sclk_a), .sout(sout_a), .sframe(sfr_a));

  debug_stream_serializer #(.DATA_WIDTH(40), .FIFO_DEPTH(4), .CLK_DIV(8), .GAP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .data_valid(dv_b), .data(d_b), .data_ready(rdy_b),
    .overflow_clr(oclr_b), .overflow(ovf_b), .fifo_level(lvl_b), .busy(busy_b),
    .sclk(sclk_b), .sout(sout_b), .sframe(sfr_b));

  debug_stream_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CLK_DIV(1), .GAP_BITS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .data_valid(dv_c), .data(d_c), .data_ready(rdy_c),
    .overflow_clr(oclr_c), .overflow(ovf_c), .fifo_level(lvl_c), .busy(busy_c),
    .sclk(sclk_c), .sout(sout_c), .sframe(sfr_c));

  typedef struct {
    int          inst;
    logic [39:0] word;
    int          nbits;
    int          hi;
    int          gap;
  } frame_t;

  frame_t got_q[$];
  frame_t exp_q[$];

  int tests = 0;
  int fails = 0;

  logic [2:0]  sclk_v, sout_v, sfr_v;
  assign sclk_v = {sclk_c, sclk_b, sclk_a};
  assign sout_v = {sout_c, sout_b, sout_a};
  assign sfr_v  = {sfr_c, sfr_b, sfr_a};

  logic [2:0]  psclk, psfr;
  logic [39:0] rx [3];
  int          nb [3];
  int          hi [3];
  int          lo [3];
  int          gap [3];
  int          rises [3];
  int          bad_low [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      rises[i] = 0;
      bad_low[i] = 0;
      rx[i] = '0;
      nb[i] = 0;
      hi[i] = 0;
      lo[i] = 0;
      gap[i] = 0;
    end
    psclk = '0;
    psfr  = '0;
  end

  // Frame monitor: sample sout at every sclk rise inside a frame, measure
  // high time of sframe and the low time preceding each frame, in clk cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        nb[i]    <= 0;
        hi[i]    <= 0;
        lo[i]    <= 0;
        psclk[i] <= 1'b0;
        psfr[i]  <= 1'b0;
      end else begin
        if (sfr_v[i] && !psfr[i]) begin
          gap[i]   <= lo[i];
          rises[i] <= rises[i] + 1;
          hi[i]    <= 1;
          nb[i]    <= 0;
          rx[i]    <= '0;
          lo[i]    <= 0;
        end else if (sfr_v[i]) begin
          hi[i] <= hi[i] + 1;
          if (sclk_v[i] && !psclk[i]) begin
            rx[i] <= {rx[i][38:0], sout_v[i]};
            nb[i] <= nb[i] + 1;
          end
        end else begin
          if (psfr[i]) begin
            got_q.push_back(frame_t'{i, rx[i], nb[i], hi[i], gap[i]});
            lo[i] <= 1;
          end else begin
            lo[i] <= lo[i] + 1;
          end
          if (sout_v[i]) bad_low[i] <= bad_low[i] + 1;
        end
        psclk[i] <= sclk_v[i];
        psfr[i]  <= sfr_v[i];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_frame(input int inst, input logic [39:0] w, input int nbits, input int hcyc);
    exp_q.push_back(frame_t'{inst, w, nbits, hcyc, 0});
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("frames_arrived", 64'(got_q.size()), 64'(n));
  endtask

  task automatic check_frame(input string tag, output int gap_o);
    frame_t f, e;
    gap_o = -1;
    check({tag, "_avail"}, 64'(got_q.size() > 0 && exp_q.size() > 0), 64'(1));
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      f = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_inst"},  64'(f.inst),  64'(e.inst));
      check({tag, "_word"},  64'(f.word),  64'(e.word));
      check({tag, "_nbits"}, 64'(f.nbits), 64'(e.nbits));
      check({tag, "_high"},  64'(f.hi),    64'(e.hi));
      gap_o = f.gap;
    end
  endtask

  task automatic wait_rise(input int inst, input int budget);
    int r = rises[inst];
    int k = 0;
    while (rises[inst] == r && k < budget) begin
      tick();
      k++;
    end
    check("sframe_rise_seen", 64'(rises[inst] != r), 64'(1));
  endtask

  task automatic half_period(input int inst, output int k);
    logic ps = sclk_v[inst];
    k = 0;
    while (sclk_v[inst] == ps && k < 40) begin tick(); k++; end
    ps = sclk_v[inst];
    k = 0;
    while (sclk_v[inst] == ps && k < 40) begin tick(); k++; end
  endtask

  logic [39:0] wb [6];
  logic [39:0] w3 [3];

  initial begin
    int n, g, r, cnt;
    logic ps;
    wb[0] = 40'h11_2233_4455; wb[1] = 40'hFF_0000_FFFF; wb[2] = 40'h80_0000_0001;
    wb[3] = 40'h5A_A55A_A55A; wb[4] = 40'hDE_ADBE_EF00; wb[5] = 40'h01_2345_6789;
    w3[0] = 40'hC3_0F0F_1234; w3[1] = 40'h00_FFFF_0001; w3[2] = 40'h7E_8181_7E00;
    rst_n = 1'b0;
    dv_a = 1'b1; d_a = 40'hFFFF_FFFF_FF; oclr_a = 1'b0;
    dv_b = 1'b0; d_b = '0; oclr_b = 1'b0;
    dv_c = 1'b0; d_c = '0; oclr_c = 1'b0;
    repeat (4) tick();

    // 1. reset with a valid word offered
    check("rst_sclk",   64'(sclk_a), 64'(0));
    check("rst_sout",   64'(sout_a), 64'(0));
    check("rst_sframe", 64'(sfr_a),  64'(0));
    check("rst_ovf",    64'(ovf_a),  64'(0));
    check("rst_level",  64'(lvl_a),  64'(0));
    check("rst_ready",  64'(rdy_a),  64'(1));
    check("rst_busy",   64'(busy_a), 64'(0));
    dv_a = 1'b0;
    tick();
    rst_n = 1'b1;
    half_period(0, n);
    check("sclk_half_a", 64'(n), 64'(4));
    half_period(1, n);
    check("sclk_half_b", 64'(n), 64'(8));
    half_period(2, n);
    check("sclk_half_c", 64'(n), 64'(1));

    // 2. single word on defaults
    d_a = 40'hA9_9999_9991; dv_a = 1'b1;
    expect_frame(0, 40'hA9_9999_9991, 40, 320);
    tick();
    dv_a = 1'b0;
    n = 1;
    while (!sfr_a && n < 40) begin tick(); n++; end
    check("latency_within_9", 64'(n <= 9), 64'(1));
    wait_frames(1, 600);
    check_frame("single", g);
    n = 0;
    while (busy_a && n < 100) begin tick(); n++; end
    check("single_busy_low", 64'(busy_a), 64'(0));

    // 3. three back-to-back words, pushes aligned just after an sclk fall
    ps = sclk_a; n = 0;
    while (!(ps && !sclk_a) && n < 20) begin ps = sclk_a; tick(); n++; end
    dv_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_a = w3[i];
      expect_frame(0, w3[i], 40, 320);
      tick();
    end
    dv_a = 1'b0;
    check("b2b_level_3", 64'(lvl_a), 64'(3));
    for (int i = 0; i < 3; i++) begin
      wait_rise(0, 500);
      check("b2b_level_step", 64'(lvl_a), 64'(2 - i));
    end
    wait_frames(3, 800);
    check_frame("b2b0", g);
    check_frame("b2b1", g);
    check("b2b_gap1", 64'(g), 64'(16));
    check_frame("b2b2", g);
    check("b2b_gap2", 64'(g), 64'(16));

    // 4. six offers right after reset on the CLK_DIV=8 block
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    dv_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_b = wb[i];
      check("ovf_ready", 64'(rdy_b), 64'(i < 4));
      if (i < 4) expect_frame(1, wb[i], 40, 640);
      tick();
    end
    dv_b = 1'b0;
    check("ovf_set",   64'(ovf_b), 64'(1));
    check("ovf_level", 64'(lvl_b), 64'(4));
    oclr_b = 1'b1;
    tick();
    oclr_b = 1'b0;
    check("ovf_cleared", 64'(ovf_b), 64'(0));
    dv_b = 1'b1; oclr_b = 1'b1;
    tick();
    dv_b = 1'b0; oclr_b = 1'b0;
    check("ovf_set_wins", 64'(ovf_b), 64'(1));
    wait_frames(4, 4000);
    for (int i = 0; i < 4; i++) check_frame("ovf_frame", g);
    n = 0;
    while (busy_b && n < 200) begin tick(); n++; end
    check("ovf_busy_low", 64'(busy_b), 64'(0));
    repeat (50) tick();
    check("ovf_no_extra_frames", 64'(got_q.size()), 64'(0));

    // 5. reset in the middle of a frame with another word queued
    dv_a = 1'b1; d_a = 40'hF0_F0F0_F0F0;
    tick();
    d_a = 40'h0F_0F0F_0F0F;
    tick();
    dv_a = 1'b0;
    wait_rise(0, 40);
    check("abort_level_before", 64'(lvl_a), 64'(1));
    ps = sclk_a; cnt = 0; n = 0;
    while (cnt < 10 && n < 200) begin
      tick();
      if (sclk_a && !ps) cnt++;
      ps = sclk_a;
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_sout",   64'(sout_a), 64'(0));
    check("abort_sframe", 64'(sfr_a),  64'(0));
    check("abort_sclk",   64'(sclk_a), 64'(0));
    check("abort_level",  64'(lvl_a),  64'(0));
    check("abort_ready",  64'(rdy_a),  64'(1));
    tick();
    rst_n = 1'b1;
    r = rises[0];
    repeat (800) tick();
    check("abort_no_residual_rise", 64'(rises[0]), 64'(r));
    check("abort_no_residual_frame", 64'(got_q.size()), 64'(0));

    // 6. 8-bit block, one clk per half-period, one-bit gap
    dv_c = 1'b1;
    d_c = 8'h81;
    expect_frame(2, 40'h81, 8, 16);
    tick();
    d_c = 8'h5A;
    expect_frame(2, 40'h5A, 8, 16);
    tick();
    dv_c = 1'b0;
    wait_frames(2, 200);
    check_frame("w8_81", g);
    check_frame("w8_5a", g);
    check("w8_gap", 64'(g), 64'(2));

    for (int i = 0; i < 3; i++) check("sout_low_outside_frame", 64'(bad_low[i]), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_stream_serializer.md
Name: debug_stream_serializer

Overview:
- Parametrised successor to the 40-bit debug data sender: a single-clock serializer that queues debug words in a FIFO and shifts them out MSB-first on a generated bit clock with frame strobe.
- Sits between internal debug/probe logic (word producer) and a header-pin logic analyser or MCU (bit consumer).
- Adds over the previous generation: configurable width, buffering depth, bit rate and inter-frame gap; valid/ready backpressure; and a sticky overflow flag.

Parameters:
- DATA_WIDTH, 40, payload bits per frame (>=2).
- FIFO_DEPTH, 4, words buffered; power of 2, >=2.
- CLK_DIV, 4, clk cycles per sclk half-period (>=1); one bit period = 2*CLK_DIV clk cycles.
- GAP_BITS, 2, idle bit periods between back-to-back frames (>=1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_valid  in  1  producer has a word on data.
- data  in  DATA_WIDTH  word to send.
- data_ready  out  1  FIFO not full; word accepted when data_valid&&data_ready.
- overflow_clr  in  1  single-cycle clear of overflow.
- overflow  out  1  sticky: a word was offered while full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently queued (excludes word in shifter).
- busy  out  1  state!=IDLE or fifo_level!=0.
- sclk  out  1  free-running bit clock; receiver samples sout on sclk rising edge.
- sout  out  1  serial data, MSB first.
- sframe  out  1  high exactly while payload bits are driven.

Behaviour:
- Reset (async, immediate): sclk=0, sout=0, sframe=0, overflow=0, fifo_level=0, data_ready=1, busy=0, divider=0, state=IDLE. Any frame in progress is aborted; FIFO contents discarded.
- Divider: div_cnt counts 0..CLK_DIV-1 continuously from reset; sclk toggles on the clk edge where div_cnt==CLK_DIV-1. fall_tick = (div_cnt==CLK_DIV-1 && sclk==1). sout/sframe update only on fall_tick edges, so they are stable for a full half-period around each sclk rise.
- FIFO: data_ready = !full, computed from registered level. Push on valid&&ready; a push while full is rejected even if a pop occurs in the same cycle. Simultaneous push and pop: level unchanged. Order strictly preserved.
- Overflow: set on any cycle with data_valid&&!data_ready; cleared by overflow_clr; set wins over clear in the same cycle.
- FSM (all transitions on fall_tick only):
  - IDLE: sout=0, sframe=0. If FIFO non-empty: pop head into shifter, sout=MSB, sframe=1, bit_cnt=1 -> SHIFT.
  - SHIFT: if bit_cnt==DATA_WIDTH: sout=0, sframe=0, gap_cnt=0 -> GAP. Else shift left, sout=next bit, bit_cnt+1.
  - GAP: sout=0, sframe=0. If gap_cnt==GAP_BITS-1: load next word (as IDLE) if FIFO non-empty, else -> IDLE. Otherwise gap_cnt+1.
- Timing results:
  - A frame occupies exactly DATA_WIDTH bit periods.
  - Back-to-back frames are separated by exactly GAP_BITS bit periods with sout=0 and sframe=0.
  - Latency from acceptance into an empty, idle block to sframe rising is at most 2*CLK_DIV+1 clk cycles.
- Counter widths: bit_cnt is sized to hold DATA_WIDTH and gap_cnt to hold GAP_BITS; neither wraps.
- busy drops on the fall_tick that enters IDLE with an empty FIFO.

Test Plan:
1. Reset: hold rst_n=0 with data_valid=1 -> all outputs at reset values, no push, overflow stays 0; release -> sclk toggles every CLK_DIV clks.
2. Single word, defaults, data=40'hA999999991 -> on 40 sclk rising edges with sframe=1, sampled sout equals the word MSB-first; sframe high exactly 320 clk cycles; then busy=0.
3. Three words pushed back-to-back, GAP_BITS=2, CLK_DIV=4 -> three frames in push order, each gap exactly 16 clk cycles with sout=0 and sframe=0; fifo_level steps 3,2,1,0 (one decrement per load).
4. CLK_DIV=8, six pushes in consecutive cycles immediately after reset -> first four accepted, data_ready=0 from the 5th cycle, overflow=1; only words 1-4 transmitted. overflow_clr pulse -> overflow=0. overflow_clr in the same cycle as a rejected push -> overflow stays 1.
5. rst_n asserted after 10 payload bits -> sout=0, sframe=0, sclk=0, fifo_level=0, data_ready=1 with no clk edge; after release, no residual frame appears.
6. DATA_WIDTH=8, CLK_DIV=1, GAP_BITS=1, data=8'h81 -> bits 1,0,0,0,0,0,0,1; frame spans 16 clk cycles.
